ram_n: RTL and testbench
========================

# ram_n

Parametrised successor to the fixed 8×16 RAM. It provides a WIDTH×2^ADDR_W word memory with single-port write, asynchronous or registered read, and a built-in clear engine. The clear engine zeroes every word after reset, or on request, one word per cycle. It sits between the CPU data path and memory-map decode as the generic storage for RAM64 and larger banks, replacing hand-instantiated register trees.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (≥1)
- ADDR_W, 3, address width; DEPTH = 2^ADDR_W words (ADDR_W ≥1)
- REG_OUT, 0, 0 = combinational read path; 1 = registered read (1-cycle latency)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; one clock, reset async active-low (fixed)
- in  in  WIDTH  write data
- addr  in  ADDR_W  read/write address
- load  in  1  write strobe; mem[addr] <= in at edge when accepted
- clear  in  1  request full-memory zero sweep
- out  out  WIDTH  read data
- busy  out  1  high while clear sweep runs; loads ignored

## Operation
- The storage array has no reset. Reset acts on the FSM, the sweep pointer `ptr` (ADDR_W bits), and the out register. Array contents are defined only after the first sweep completes.
- FSM states: CLEAR, IDLE.
  - reset low → CLEAR, ptr=0, out=0 (REG_OUT=1), busy=1.
  - CLEAR: each edge writes mem[ptr] <= 0 and increments ptr. At ptr==DEPTH-1, that word is written and the FSM moves to IDLE. The sweep takes exactly DEPTH cycles.
  - CLEAR with clear=1: ptr restarts at 0 and the sweep restarts.
  - IDLE with clear=1: → CLEAR, ptr=0. A load in the same cycle is dropped (clear wins).
  - IDLE with load=1 and clear=0: mem[addr] <= in.
- busy = (state==CLEAR). It is combinational from state.
- While busy=1:
  - load is ignored.
  - out is forced to 0, for both REG_OUT values.
- Read in REG_OUT=0: out = mem[addr] combinationally. A same-cycle write to the same addr shows the old value until the edge, then the new one.
- Read in REG_OUT=1: out <= mem[addr] at each edge in IDLE. Reads are read-first: a same-edge write to addr returns the old value, and the new value appears one edge later.
- Address arithmetic is modulo DEPTH. ptr wraps only via the DEPTH-1 termination, never past it.

## Timing
- Reset release: busy=1 for DEPTH rising edges after the first edge with reset high. busy falls combinationally after the DEPTH-th edge.
- Write latency: 1 edge.
- Read latency: 0 (REG_OUT=0) or 1 edge (REG_OUT=1).
- First accepted load: on the edge where state==IDLE.
- Reset asserted mid-sweep or mid-operation: immediate return to CLEAR, ptr=0, and out=0 with no clock needed. Array words already written keep their values, but are overwritten by the new sweep.
- clear held high continuously keeps busy=1 indefinitely, with ptr pinned at 0.

## Structure
- Shared package `ram_pkg`:
  - state encoding localparams (ST_CLEAR=1'b1, ST_IDLE=1'b0)
  - a DEPTH derivation helper, reused by ram_n instances at all bank sizes
- One sub-module, `ram_clear_fsm`: state, ptr, and generation of busy, the sweep write enable and the sweep address. ram_n muxes the sweep write and the user write into the array.
- Array as a reg vector; no register/mux16 tree instantiation.

## Test plan
- Reset then idle, default parameters:
  - busy=1 for exactly 8 edges, then 0.
  - Reading all 8 addresses returns 0x0000.
- Write/read: load 0xBEEF@3, 0x1234@7 → addr=3 out=0xBEEF and addr=7 out=0x1234 (REG_OUT=0 same cycle; REG_OUT=1 one edge later).
- Same-address read/write, REG_OUT=1: mem[5]=0x0001, then load 0x00FF@5 while addr=5 → out=0x0001 after that edge, 0x00FF after the next.
- Clear in IDLE with simultaneous load 0xAAAA@2 → load dropped; busy=1 for 8 edges; all words read 0 afterward, including the prior 0xBEEF@3.
- Clear re-asserted at sweep cycle 4 → busy stays 1 for 8 more edges (12 total); loads during busy leave memory at 0.
- Reset pulsed low mid-sweep, plus a sweep with WIDTH=8, ADDR_W=6 → async return to busy=1, out=0; sweep takes 64 edges after release.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding and depth helper for the ram_n storage family.
// Rev 1.0
`default_nettype none

package ram_pkg;

  localparam logic ST_CLEAR = 1'b1;
  localparam logic ST_IDLE  = 1'b0;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_CLEAR = ST_CLEAR
  } state_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_clear_fsm.sv
// ram_clear_fsm: zero-sweep sequencer; walks ptr across every word after reset or on request.
// Rev 1.0
`default_nettype none

module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              busy,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  // DEPTH is a power of two, so the last sweep address is all ones.
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (clear) begin
            ptr <= '0;
          end else if (ptr == LAST) begin
            state <= S_IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          if (clear) begin
            state <= S_CLEAR;
            ptr   <= '0;
          end
        end
      endcase
    end
  end

  assign busy       = (state == S_CLEAR);
  assign sweep_we   = busy;
  assign sweep_addr = ptr;

endmodule

`default_nettype wire

// File: rtl/ram_n.sv
// ram_n: WIDTH x 2^ADDR_W single-port RAM with async/registered read and a zeroing sweep.
// Rev 1.0
`default_nettype none

module ram_n
  import ram_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 3,
  parameter int REG_OUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              user_we;
  logic [WIDTH-1:0]  rd_data;

  ram_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  // A clear request in the same cycle wins over a user write.
  assign user_we = load & ~clear & ~busy;

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (user_we) begin
      mem[addr] <= in;
    end
  end

  assign rd_data = mem[addr];

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [WIDTH-1:0] out_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          out_q <= '0;
        end else if (busy) begin
          out_q <= '0;
        end else begin
          out_q <= rd_data;
        end
      end

      assign out = busy ? '0 : out_q;
    end else begin : g_comb_out
      assign out = busy ? '0 : rd_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ram_n.sv
// tb_ram_n: scoreboard bench for ram_n (combinational, registered and wide/deep instances).
// Rev 1.0
`default_nettype none

module tb_ram_n;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic [2:0]  addr;
  logic        load;
  logic        clear;
  logic [15:0] out0, out1;
  logic        busy0, busy1;

  logic        reset2;
  logic [7:0]  din2;
  logic [5:0]  addr2;
  logic        load2;
  logic        clear2;
  logic [7:0]  out2;
  logic        busy2;

  int asserts;
  int fails;

  logic [15:0] model [8];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [7:0]  q2 [$];
  logic [15:0] exp16;
  logic [7:0]  exp8;
  int          n;

  ram_n #(.WIDTH(16), .ADDR_W(3), .REG_OUT(0)) dut0 (
    .clk(clk), .reset(reset), .in(din), .addr(addr), .load(load),
    .clear(clear), .out(out0), .busy(busy0)
  );

  ram_n #(.WIDTH(16), .ADDR_W(3), .REG_OUT(1)) dut1 (
    .clk(clk), .reset(reset), .in(din), .addr(addr), .load(load),
    .clear(clear), .out(out1), .busy(busy1)
  );

  ram_n #(.WIDTH(8), .ADDR_W(6), .REG_OUT(1)) dut2 (
    .clk(clk), .reset(reset2), .in(din2), .addr(addr2), .load(load2),
    .clear(clear2), .out(out2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    asserts++;
    if (busy0 !== 1'b1) begin fails++; $display("FAIL reset_busy0: got %b expected 1", busy0); end
    asserts++;
    if (out1 !== 16'h0000) begin fails++; $display("FAIL reset_out1: got %h expected 0000", out1); end
    tick();
    tick();
    reset = 1'b1;
    n = 0;
    while (busy0 && n < 50) begin tick(); n++; end
    asserts++;
    if (n != 8) begin fails++; $display("FAIL reset_sweep_len: got %0d edges expected 8", n); end
    asserts++;
    if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy1_end: got %b expected 0", busy1); end
    for (int a = 0; a < 8; a++) model[a] = 16'h0000;
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      q0.push_back(model[a]);
      q1.push_back(model[a]);
      #1;
      exp16 = q0.pop_front();
      asserts++;
      if (out0 !== exp16) begin fails++; $display("FAIL reset_read0[%0d]: got %h expected %h", a, out0, exp16); end
      tick();
      exp16 = q1.pop_front();
      asserts++;
      if (out1 !== exp16) begin fails++; $display("FAIL reset_read1[%0d]: got %h expected %h", a, out1, exp16); end
    end
  endtask

  task automatic test_write_read();
    addr = 3'd3; din = 16'hBEEF; load = 1'b1; model[3] = 16'hBEEF;
    tick();
    addr = 3'd7; din = 16'h1234; model[7] = 16'h1234;
    tick();
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      addr = (k == 0) ? 3'd3 : 3'd7;
      q0.push_back(model[addr]);
      q1.push_back(model[addr]);
      #1;
      exp16 = q0.pop_front();
      asserts++;
      if (out0 !== exp16) begin fails++; $display("FAIL wr_read0@%0d: got %h expected %h", addr, out0, exp16); end
      asserts++;
      if (out1 === exp16 && k == 1) begin fails++; $display("FAIL wr_read1_early@%0d: got %h expected stale value", addr, out1); end
      tick();
      exp16 = q1.pop_front();
      asserts++;
      if (out1 !== exp16) begin fails++; $display("FAIL wr_read1@%0d: got %h expected %h", addr, out1, exp16); end
    end
  endtask

  task automatic test_same_addr();
    addr = 3'd5; din = 16'h0001; load = 1'b1; model[5] = 16'h0001;
    tick();
    din = 16'h00FF;
    q1.push_back(model[5]);
    model[5] = 16'h00FF;
    tick();
    load = 1'b0;
    exp16 = q1.pop_front();
    asserts++;
    if (out1 !== exp16) begin fails++; $display("FAIL same_addr_old: got %h expected %h", out1, exp16); end
    asserts++;
    if (out0 !== model[5]) begin fails++; $display("FAIL same_addr_comb: got %h expected %h", out0, model[5]); end
    q1.push_back(model[5]);
    tick();
    exp16 = q1.pop_front();
    asserts++;
    if (out1 !== exp16) begin fails++; $display("FAIL same_addr_new: got %h expected %h", out1, exp16); end
  endtask

  task automatic test_clear_idle();
    addr = 3'd2; din = 16'hAAAA; load = 1'b1; clear = 1'b1;
    tick();
    load = 1'b0; clear = 1'b0;
    asserts++;
    if (busy0 !== 1'b1) begin fails++; $display("FAIL clr_busy: got %b expected 1", busy0); end
    asserts++;
    if (out0 !== 16'h0000 || out1 !== 16'h0000) begin
      fails++; $display("FAIL clr_out_forced: got %h/%h expected 0000/0000", out0, out1);
    end
    for (int a = 0; a < 8; a++) model[a] = 16'h0000;
    n = 0;
    while (busy0 && n < 50) begin tick(); n++; end
    asserts++;
    if (n != 8) begin fails++; $display("FAIL clr_sweep_len: got %0d edges expected 8", n); end
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      q0.push_back(model[a]);
      q1.push_back(model[a]);
      #1;
      exp16 = q0.pop_front();
      asserts++;
      if (out0 !== exp16) begin fails++; $display("FAIL clr_read0[%0d]: got %h expected %h", a, out0, exp16); end
      tick();
      exp16 = q1.pop_front();
      asserts++;
      if (out1 !== exp16) begin fails++; $display("FAIL clr_read1[%0d]: got %h expected %h", a, out1, exp16); end
    end
  endtask

  task automatic test_clear_restart();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    load = 1'b1; din = 16'hFFFF; addr = 3'd1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      asserts++;
      if (busy0 !== 1'b1) begin fails++; $display("FAIL restart_busy[%0d]: got %b expected 1", i, busy0); end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    while (busy0 && n < 50) begin tick(); n++; end
    load = 1'b0;
    asserts++;
    if (4 + n != 12) begin fails++; $display("FAIL restart_sweep_len: got %0d edges expected 12", 4 + n); end
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      q0.push_back(model[a]);
      #1;
      exp16 = q0.pop_front();
      asserts++;
      if (out0 !== exp16) begin fails++; $display("FAIL restart_read0[%0d]: got %h expected %h", a, out0, exp16); end
    end
  endtask

  task automatic test_reset_wide();
    reset2 = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    #2;
    reset2 = 1'b0;
    #1;
    asserts++;
    if (busy2 !== 1'b1 || out2 !== 8'h00) begin
      fails++; $display("FAIL wide_midsweep_reset: got busy=%b out=%h expected busy=1 out=00", busy2, out2);
    end
    tick();
    reset2 = 1'b1;
    n = 0;
    while (busy2 && n < 200) begin tick(); n++; end
    asserts++;
    if (n != 64) begin fails++; $display("FAIL wide_sweep_len: got %0d edges expected 64", n); end
    addr2 = 6'd40; din2 = 8'h5A; load2 = 1'b1;
    q2.push_back(8'h5A);
    tick();
    load2 = 1'b0;
    tick();
    exp8 = q2.pop_front();
    asserts++;
    if (out2 !== exp8) begin fails++; $display("FAIL wide_read: got %h expected %h", out2, exp8); end
    #2;
    reset2 = 1'b0;
    #1;
    asserts++;
    if (busy2 !== 1'b1 || out2 !== 8'h00) begin
      fails++; $display("FAIL wide_idle_reset: got busy=%b out=%h expected busy=1 out=00", busy2, out2);
    end
    tick();
    reset2 = 1'b1;
    n = 0;
    while (busy2 && n < 200) begin tick(); n++; end
    asserts++;
    if (n != 64) begin fails++; $display("FAIL wide_sweep_len2: got %0d edges expected 64", n); end
    q2.push_back(8'h00);
    tick();
    exp8 = q2.pop_front();
    asserts++;
    if (out2 !== exp8) begin fails++; $display("FAIL wide_read_cleared: got %h expected %h", out2, exp8); end
  endtask

  initial begin
    asserts = 0; fails = 0;
    reset = 1'b1; din = '0; addr = '0; load = 1'b0; clear = 1'b0;
    reset2 = 1'b1; din2 = '0; addr2 = '0; load2 = 1'b0; clear2 = 1'b0;
    #2;
    reset = 1'b0;
    reset2 = 1'b0;
    test_reset();
    test_write_read();
    test_same_addr();
    test_clear_idle();
    test_clear_restart();
    test_reset_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

`default_nettype wire
